lives_row_locator: RTL
======================

// Module: lives_row_locator
// PURPOSE
//  Position/state source for the lives-icon bitmap drawer. Owns the player lives counter.
//  Per pixel, tells the drawer whether the scan point lies inside a visible life icon and
//  gives the offset inside that icon.
//  Icons form one horizontal row. The icon being lost after a hit blinks during a
//  grace period. Sits between the VGA pixel scanner / game controller and the drawer.
// PARAMETERS
//  MAX_LIVES     3    lives at reset and saturation ceiling (1..7)
//  TOP_LEFT_X    16   x of icon 0 left edge, pixels
//  TOP_LEFT_Y    8    y of icon row top edge, pixels
//  ICON_LOG      3    log2 of icon bitmap side (8x8)
//  SCALE_LOG     0    screen pixels per bitmap pixel = 2**SCALE_LOG
//  GAP           4    screen pixels between adjacent icons
//  GRACE_FRAMES  64   frames after a hit during which further hits are ignored
//  BLINK_BIT     3    frame-counter bit controlling blink phase
// PORTS
//  clk              in   1   system clock
//  reset            in   1   synchronous, active-high reset
//  startOfFrame     in   1   one-cycle pulse per video frame
//  pixelX           in   11  current scan x (coordinate)
//  pixelY           in   11  current scan y (coordinate)
//  player_hit       in   1   one-cycle pulse: player struck
//  extra_life       in   1   one-cycle pulse: award one life
//  offsetX          out  11  x offset inside hit icon, bitmap units (0..2**ICON_LOG-1)
//  offsetY          out  11  y offset inside hit icon, bitmap units
//  InsideRectangle  out  1   scan point inside a visible icon
//  lives            out  3   current lives count
//  in_grace         out  1   grace period active
//  game_over        out  1   lives reached 0 (sticky until reset)
// BEHAVIOUR
//  - All state is synchronous to clk. reset: lives=MAX_LIVES, grace counter=0,
//    frame counter=0, in_grace=0, game_over=0, InsideRectangle=0, offsetX=offsetY=0.
//  - Icon geometry: SIDE=2**(ICON_LOG+SCALE_LOG). Icon i occupies
//    x in [TOP_LEFT_X+i*(SIDE+GAP), +SIDE) and y in [TOP_LEFT_Y, +SIDE),
//    for i = 0..MAX_LIVES-1. Stride products are elaboration constants; no runtime multiply.
//  - Visibility: icon i is visible iff i < lives, OR (i == lives AND in_grace AND blink_on).
//  - Locator latency is exactly 1 clk: the registered outputs at cycle n+1 reflect the
//    pixelX/pixelY of cycle n.
//  - Offset: offsetX=(pixelX-left_i)>>SCALE_LOG and offsetY=(pixelY-TOP_LEFT_Y)>>SCALE_LOG,
//    zero-extended to 11 bits. Outside any visible icon: InsideRectangle=0, offsets=0.
//  - Edge pixels: the right/bottom edge (left+SIDE) is outside. Gap pixels are outside.
//  - Coordinate compares are signed 11-bit; negative pixel values are never inside.
//  - Lives FSM states:
//    - ALIVE (lives>0, !in_grace)
//    - GRACE (in_grace)
//    - DEAD (game_over)
//  - ALIVE + player_hit: lives-=1, grace counter=GRACE_FRAMES, in_grace=1 next cycle.
//    If the new lives==0, go to DEAD instead: game_over=1, in_grace=0.
//  - GRACE: player_hit is ignored. The counter decrements on each startOfFrame.
//    At 0, in_grace=0 and the FSM returns to ALIVE.
//  - extra_life in ALIVE or GRACE: lives+=1, saturating at MAX_LIVES. It does not
//    change the grace state. Ignored in DEAD.
//  - player_hit and extra_life in the same cycle: the hit is processed and extra_life
//    is dropped.
//  - Frame counter: 8 bits, increments on startOfFrame, wraps; reset only by reset.
//    blink_on = frame_cnt[BLINK_BIT].
//  - reset asserted mid-grace or mid-frame restores all reset values on the next edge.
// CONFIGURATION
//  LIVES_BLINK_EN defined: the lost icon (i==lives) blinks while in_grace.
//  LIVES_BLINK_EN undefined: the blink term is removed and the lost icon disappears
//    immediately. The grace timer and hit masking are still present.
// TESTING
//  1 reset; pixel (30,10) -> next clk InsideRectangle=1, offsetX=2, offsetY=2 (icon 1).
//  2 pixel (36,10) gap and (16,16) bottom edge -> InsideRectangle=0, offsets 0.
//  3 player_hit -> lives=2, in_grace=1. A hit 5 frames later is ignored. After 64 startOfFrame
//    pulses in_grace=0; the next hit gives lives=1.
//  4 blink: in grace after hit, pixel (42,8) -> InsideRectangle follows frame_cnt[3]
//    with LIVES_BLINK_EN defined, and is constantly 0 with it undefined.
//  5 extra_life at lives=3 -> stays 3. player_hit and extra_life in the same cycle at 3 -> 2.
//  6 three hits separated by grace -> lives=0, game_over=1, no icons drawn.
//    extra_life is ignored; reset -> lives=3, game_over=0.

Source files
------------

// File: rtl/lives_row_locator.sv
// lives_row_locator
//   Owns the player lives counter and, for every scan pixel, reports whether the
//   point lies inside a visible lives icon plus the bitmap offset inside that icon.
//   Icons sit in one horizontal row; icon i is shown while i < lives. After a hit,
//   a grace period masks further hits, and the icon just lost may blink.
//   Optional feature macro: LIVES_BLINK_EN
//     defined   -> the lost icon (index == lives) blinks on frame_cnt[BLINK_BIT]
//                  while the grace period runs.
//     undefined -> the lost icon disappears immediately; grace timing is unchanged.
module lives_row_locator #(
    parameter int MAX_LIVES    = 3,
    parameter int TOP_LEFT_X   = 16,
    parameter int TOP_LEFT_Y   = 8,
    parameter int ICON_LOG     = 3,
    parameter int SCALE_LOG    = 0,
    parameter int GAP          = 4,
    parameter int GRACE_FRAMES = 64,
    parameter int BLINK_BIT    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        player_hit,
    input  logic        extra_life,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic [2:0]  lives,
    output logic        in_grace,
    output logic        game_over
);

    // ------------------------------------------------------------------
    // Elaboration-time geometry; icon left edges are constants per icon.
    // ------------------------------------------------------------------
    localparam int SIDE   = 2 ** (ICON_LOG + SCALE_LOG);
    localparam int STRIDE = SIDE + GAP;
    localparam int GW     = $clog2(GRACE_FRAMES + 1);

    localparam logic [2:0]         LIVES_MAX  = 3'(MAX_LIVES);
    localparam logic [GW-1:0]      GRACE_INIT = GW'(GRACE_FRAMES);
    localparam logic [GW-1:0]      GRACE_ONE  = GW'(1);
    localparam logic signed [12:0] SIDE_S     = 13'(SIDE);
    localparam logic signed [12:0] TOP_S      = 13'(TOP_LEFT_Y);

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_GRACE = 2'd1,
        ST_DEAD  = 2'd2
    } life_state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    life_state_e     state_q, state_d;
    logic [2:0]      lives_q, lives_d;
    logic [GW-1:0]   grace_cnt_q, grace_cnt_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic            inside_q, inside_d;
    logic [10:0]     offset_x_q, offset_x_d;
    logic [10:0]     offset_y_q, offset_y_d;

    // ------------------------------------------------------------------
    // Blink phase
    // ------------------------------------------------------------------
    logic blink_phase;
    logic blink_on;
    logic unused_frame_bits;

    assign blink_phase       = frame_cnt_q[BLINK_BIT];
    // Only one frame-counter bit drives the picture; the rest just count.
    assign unused_frame_bits = ^frame_cnt_q;

`ifdef LIVES_BLINK_EN
    assign blink_on = blink_phase;
`else
    logic unused_blink_phase;
    assign unused_blink_phase = blink_phase;
    assign blink_on           = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Per-icon hit detection. Coordinates are treated as signed 11-bit and
    // extended to 13 bits so the subtraction never wraps; a negative
    // difference always means "left of / above" the icon.
    // ------------------------------------------------------------------
    logic signed [12:0] px_s;
    logic signed [12:0] py_s;
    logic signed [12:0] dy;
    logic               in_row;

    assign px_s   = {{2{pixelX[10]}}, pixelX};
    assign py_s   = {{2{pixelY[10]}}, pixelY};
    assign dy     = py_s - TOP_S;
    assign in_row = (dy >= 13'sd0) && (dy < SIDE_S);

    logic [MAX_LIVES-1:0] icon_hit;
    logic [10:0]          icon_dx [MAX_LIVES];

    for (genvar i = 0; i < MAX_LIVES; i++) begin : g_icon
        localparam logic signed [12:0] LEFT = 13'(TOP_LEFT_X + i * STRIDE);
        logic signed [12:0] dx;
        logic               visible;

        assign dx          = px_s - LEFT;
        // The icon at index == lives is the one most recently lost.
        assign visible     = (3'(i) < lives_q) ||
                             ((3'(i) == lives_q) && (state_q == ST_GRACE) && blink_on);
        assign icon_hit[i] = visible && in_row && (dx >= 13'sd0) && (dx < SIDE_S);
        assign icon_dx[i]  = dx[10:0];
    end

    // Locator next state: pick the (unique) icon under the scan point.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        inside_d   = 1'b0;
        offset_x_d = '0;
        offset_y_d = '0;
        for (int i = 0; i < MAX_LIVES; i++) begin
            if (icon_hit[i]) begin
                inside_d   = 1'b1;
                offset_x_d = icon_dx[i] >> SCALE_LOG;
                offset_y_d = dy[10:0] >> SCALE_LOG;
            end
        end
    end

    // Frame counter next state: free-running, wraps at 256 frames.
    always_comb begin
        frame_cnt_d = frame_cnt_q + 8'(startOfFrame);
    end

    // Lives FSM next state: hit, grace countdown and extra-life handling.
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        grace_cnt_d = grace_cnt_q;

        case (state_q)
            ST_ALIVE: begin
                // A simultaneous extra_life is dropped when a hit lands.
                if (player_hit) begin
                    lives_d = lives_q - 3'd1;
                    if (lives_q == 3'd1) begin
                        state_d     = ST_DEAD;
                        grace_cnt_d = '0;
                    end else begin
                        state_d     = ST_GRACE;
                        grace_cnt_d = GRACE_INIT;
                    end
                end else if (extra_life && (lives_q < LIVES_MAX)) begin
                    lives_d = lives_q + 3'd1;
                end
            end

            ST_GRACE: begin
                // Hits are masked here; an extra life still counts.
                if (extra_life && (lives_q < LIVES_MAX)) begin
                    lives_d = lives_q + 3'd1;
                end
                if (grace_cnt_q == '0) begin
                    state_d = ST_ALIVE;
                end else if (startOfFrame) begin
                    grace_cnt_d = grace_cnt_q - GRACE_ONE;
                    if (grace_cnt_q == GRACE_ONE) begin
                        state_d = ST_ALIVE;
                    end
                end
            end

            ST_DEAD: begin
                // Sticky until reset.
            end

            default: begin
                state_d = ST_DEAD;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= ST_ALIVE;
            lives_q     <= LIVES_MAX;
            grace_cnt_q <= '0;
            frame_cnt_q <= '0;
            inside_q    <= 1'b0;
            offset_x_q  <= '0;
            offset_y_q  <= '0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            grace_cnt_q <= grace_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            inside_q    <= inside_d;
            offset_x_q  <= offset_x_d;
            offset_y_q  <= offset_y_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign InsideRectangle = inside_q;
    assign offsetX         = offset_x_q;
    assign offsetY         = offset_y_q;
    assign lives           = lives_q;
    assign in_grace        = (state_q == ST_GRACE);
    assign game_over       = (state_q == ST_DEAD);

endmodule
